rr_issue_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream issue port among `WIDTH` requesters using a valid/ready handshake. It sits between the issue-queue request vectors and a single execution or writeback port. Priority selection scans from the highest index downward. The selected request and its payload are registered and held stable until the downstream side accepts them.

---
 rtl/rr_issue_arbiter_pkg.sv | 22 ++
 rtl/rr_issue_arbiter_if.sv | 26 ++
 rtl/rr_issue_arbiter_find_last1.sv | 19 +
 rtl/rr_issue_arbiter.sv | 116 +++++++++++
 tb/tb_rr_issue_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/rr_issue_arbiter_pkg.sv
// Shared types and helpers for the round-robin issue arbiter.
// Holds the FSM state encoding and a one-hot to binary index converter.
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_W = 256;

    // Fixed maximum width; callers zero-extend their one-hot and truncate the result.
    function automatic logic [7:0] onehot_to_idx(input logic [ARB_MAX_W-1:0] oh);
        logic [7:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (oh[i]) idx = idx | 8'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_issue_arbiter_if.sv
// Request/issue handshake bundle between the requesters, the arbiter and the downstream port.
// master: the arbiter side; slave: the requesters plus the downstream consumer.
interface rr_issue_arbiter_if #(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(WIDTH)
);
    logic [WIDTH-1:0]        req_valid;
    logic [WIDTH*DATA_W-1:0] req_data;
    logic [WIDTH-1:0]        req_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_sel;
    logic [IDX_W-1:0]        out_idx;
    logic [DATA_W-1:0]       out_data;
    logic                    out_ready;

    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_sel, out_idx, out_data
    );

    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_sel, out_idx, out_data
    );
endinterface

// File: rtl/rr_issue_arbiter_find_last1.sv
// Priority encoder: one-hot of the highest set bit of vec.
// With no bit set it returns the MSB, so callers must gate the result with |vec.
module find_last1 #(
    parameter int W = 4
) (
    input  logic [W-1:0] vec,
    output logic [W-1:0] hit
);
    always_comb begin
        hit        = '0;
        hit[W-1]   = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_issue_arbiter.sv
// Round-robin arbiter sharing one registered issue port among WIDTH requesters.
// Optional perf counters are built when RR_ISSUE_ARB_PERF_EN is defined.
//
// state    | meaning
// ARB_IDLE | no grant held, out_valid low
// ARB_BUSY | grant held stable in sel_q/idx_q/data_q until out_ready
module rr_issue_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    rr_issue_arbiter_if.master  bus
`ifdef RR_ISSUE_ARB_PERF_EN
    ,
    output logic [31:0]         perf_fire_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);
    localparam int IDX_W = $clog2(WIDTH);

    arb_state_t          state_q, state_d;
    logic                firing, load;
    logic [WIDTH-1:0]    sel_q, last_q, last_eff;
    logic [WIDTH-1:0]    cand, mask_c, hit_m, hit_c, next_sel;
    logic                any_m, any_c;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   data_q, next_data;

    assign firing = (state_q == ARB_BUSY) && bus.out_ready;

    // On a fire the just-issued requester sits out this selection and becomes the new pointer.
    assign cand     = firing ? (bus.req_valid & ~sel_q) : bus.req_valid;
    assign last_eff = firing ? sel_q : last_q;
    assign mask_c   = cand & (last_eff - WIDTH'(1));
    assign any_m    = |mask_c;
    assign any_c    = |cand;

    find_last1 #(.W(WIDTH)) u_find_masked (.vec(mask_c), .hit(hit_m));
    find_last1 #(.W(WIDTH)) u_find_full   (.vec(cand),   .hit(hit_c));

    assign next_sel = any_m ? hit_m : (any_c ? hit_c : '0);

    always_comb begin
        next_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            next_data = next_data | ({DATA_W{next_sel[i]}} & bus.req_data[i*DATA_W +: DATA_W]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_c) begin
                    state_d = ARB_BUSY;
                    load    = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (bus.out_ready) begin
                    if (any_c) load    = 1'b1;
                    else       state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            last_q <= WIDTH'(1);
        end else begin
            if (firing) last_q <= sel_q;
            if (load) begin
                sel_q  <= next_sel;
                idx_q  <= IDX_W'(onehot_to_idx(ARB_MAX_W'(next_sel)));
                data_q <= next_data;
            end else if (firing) begin
                sel_q <= '0;
                idx_q <= '0;
            end
        end
    end

    // Reset wins over a simultaneous accept, so no pulse escapes in that cycle.
    assign bus.req_ready = (firing && !reset) ? sel_q : '0;
    assign bus.out_valid = (state_q == ARB_BUSY);
    assign bus.out_sel   = sel_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_data  = data_q;

`ifdef RR_ISSUE_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fire_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (firing) perf_fire_cnt <= perf_fire_cnt + 32'd1;
            if ((state_q == ARB_BUSY) && !bus.out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// Directed bench for rr_issue_arbiter (WIDTH=4, DATA_W=32) with hand-computed expectations.
// Perf counter checks are included when RR_ISSUE_ARB_PERF_EN is defined.
module tb_rr_issue_arbiter;
    localparam int WIDTH  = 4;
    localparam int DATA_W = 32;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

`ifdef RR_ISSUE_ARB_PERF_EN
    logic [31:0] perf_fire_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [DATA_W-1:0] pay [WIDTH];

    rr_issue_arbiter_if #(.WIDTH(WIDTH), .DATA_W(DATA_W)) bus ();

    rr_issue_arbiter #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef RR_ISSUE_ARB_PERF_EN
        ,
        .perf_fire_cnt  (perf_fire_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [3:0] sel,
                             input logic [1:0] idx, input logic [3:0] rdy);
        check_val({tag, "_valid"}, 64'(bus.out_valid), 64'(vld));
        check_val({tag, "_sel"},   64'(bus.out_sel),   64'(sel));
        check_val({tag, "_idx"},   64'(bus.out_idx),   64'(idx));
        check_val({tag, "_ready"}, 64'(bus.req_ready), 64'(rdy));
    endtask

    initial begin
        int          exp_idx [5];
        logic [3:0]  one;

        n_checks = 0;
        n_errors = 0;
        pay[0] = 32'h1000_00a0;
        pay[1] = 32'h2000_01b1;
        pay[2] = 32'h3000_02c2;
        pay[3] = 32'h4000_03d3;
        bus.req_data  = {pay[3], pay[2], pay[1], pay[0]};
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_out("rst", 1'b0, 4'b0000, 2'd0, 4'b0000);
        check_val("rst_data", 64'(bus.out_data), 64'(0));

        // all requesting, downstream always ready
        exp_idx = '{3, 2, 1, 0, 3};
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        check_val("rr_idle_ready", 64'(bus.req_ready), 64'(0));
        tick();
        for (int k = 0; k < 5; k++) begin
            one = 4'b0001 << exp_idx[k];
            check_out($sformatf("rr%0d", k), 1'b1, one, 2'(exp_idx[k]), one);
            check_val($sformatf("rr%0d_data", k), 64'(bus.out_data), 64'(pay[exp_idx[k]]));
            if (k == 4) bus.req_valid = 4'b0000;
            tick();
        end
        check_out("rr_end", 1'b0, 4'b0000, 2'd0, 4'b0000);

        // stall: pointer now at 3, so 0101 grants 2
        bus.req_valid = 4'b0101;
        bus.out_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) bus.req_valid = 4'b0001;
            #1;
            check_out($sformatf("stall%0d", k), 1'b1, 4'b0100, 2'd2, 4'b0000);
            check_val($sformatf("stall%0d_data", k), 64'(bus.out_data), 64'(pay[2]));
            tick();
        end
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        #1;
        check_val("stall_release_ready", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        check_out("stall_end", 1'b0, 4'b0000, 2'd0, 4'b0000);

        // lone requester 1 alternates BUSY/IDLE because it excludes itself on fire
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("solo%0d_busy", k), 1'b1, 4'b0010, 2'd1, 4'b0010);
            check_val($sformatf("solo%0d_data", k), 64'(bus.out_data), 64'(pay[1]));
            tick();
            check_out($sformatf("solo%0d_idle", k), 1'b0, 4'b0000, 2'd0, 4'b0000);
        end
        bus.req_valid = 4'b0000;

        // reset while busy with out_ready high; pointer at 1, so 0011 grants 0 first
        bus.req_valid = 4'b0011;
        bus.out_ready = 1'b0;
        tick();
        check_out("rb_pre", 1'b1, 4'b0001, 2'd0, 4'b0000);
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        #1;
        check_val("rb_no_pulse", 64'(bus.req_ready), 64'(0));
        tick();
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_out("rb_post", 1'b0, 4'b0000, 2'd0, 4'b0000);
        check_val("rb_post_data", 64'(bus.out_data), 64'(0));
        tick();
        check_out("rb_regrant", 1'b1, 4'b0010, 2'd1, 4'b0000);
        check_val("rb_regrant_data", 64'(bus.out_data), 64'(pay[1]));
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        tick();
        check_out("rb_end", 1'b0, 4'b0000, 2'd0, 4'b0000);

`ifdef RR_ISSUE_ARB_PERF_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_val("perf_rst_fire",  64'(perf_fire_cnt),  64'(0));
        check_val("perf_rst_stall", 64'(perf_stall_cnt), 64'(0));
        bus.req_valid = 4'b1100;
        bus.out_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        bus.out_ready = 1'b0;
        check_val("perf_fire",  64'(perf_fire_cnt),  64'(2));
        check_val("perf_stall", 64'(perf_stall_cnt), 64'(3));
        check_val("perf_idle",  64'(bus.out_valid),  64'(0));
`endif

        // no requests: encoder default must never leak onto the grant
        bus.req_valid = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            bus.out_ready = k[0];
            tick();
            check_out($sformatf("none%0d", k), 1'b0, 4'b0000, 2'd0, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
